cu_mod1_1: RTL and testbench
============================

# cu_mod1_1

Control unit for the second radix-2 butterfly stage (delay-1 SDF) of FFT module 1. It sits directly downstream of the stage-0 control unit and consumes that unit's per-sample qualifier and frame-start pulse. It generates:
- the stage-1 butterfly enable;
- the trivial-twiddle (−j) select for the fac8 rotation;
- the output valid and frame-start alert for the next control unit in the chain;
- frame-done and error flags.

## Interface
Parameters:
- `N_PT`, 512: samples per frame; power of two, ≥ 8.
- `CNT_W`, $clog2(N_PT): sample-counter width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `valid_fac8_0`  in  1  upstream sample qualifier; one sample per cycle when high; gaps allowed.
- `alert_mod10`  in  1  upstream frame-start pulse; coincident with the first `valid_fac8_0` of a frame.
- `bf_en`  out  1  stage-1 butterfly enable: 0 = buffer sample, 1 = add/subtract pair.
- `tw_negj`  out  1  apply −j rotation to the current output sample.
- `valid_fac8_1`  out  1  output sample qualifier to the downstream stage.
- `alert_mod11`  out  1  one-cycle frame-start pulse to the downstream stage.
- `frame_done`  out  1  one-cycle pulse on the last output slot of a frame.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
- FSM states: IDLE, RUN, DRAIN. Reset state is IDLE.
- Counters: `in_cnt` (CNT_W bits) counts accepted input samples; `out_cnt` (CNT_W bits) counts emitted output samples.
- IDLE:
  - `alert_mod10 & valid_fac8_0` → RUN, `in_cnt`=1, `bf_en`=0.
  - `valid_fac8_0` without `alert_mod10` → ignored, `err` pulse.
- RUN, on each `valid_fac8_0`:
  - `bf_en` = `in_cnt[0]`.
  - `in_cnt`++.
  - `valid_fac8_1` asserted next cycle for every accepted sample except the frame's first. The first is only buffered.
- RUN, when `valid_fac8_0` is low: all counters and outputs hold; `valid_fac8_1`=0.
- RUN, sample with `in_cnt`==N_PT−1 accepted → DRAIN.
- DRAIN (exactly one cycle):
  - emits the flush slot: `valid_fac8_1`=1, `bf_en`=0, `frame_done`=1.
  - then → IDLE.
  - Total output valids per frame = N_PT.
- DRAIN with `alert_mod10 & valid_fac8_0` in the same cycle (back-to-back frames): the flush slot is still emitted; next state is RUN with `in_cnt`=1. There is no output collision, because the new frame's first sample is only buffered.
- `alert_mod10` during RUN: `err` pulse; frame restarts (`in_cnt`=1, `out_cnt`=0); the partial frame is discarded.
- `tw_negj` = 1 when `out_cnt[1:0]`==2'b11, else 0.
- `alert_mod11` = 1 with the output slot where `out_cnt`==0.
- `out_cnt` increments on each `valid_fac8_1` and wraps to 0 after N_PT−1.

## Timing
- All outputs are registered and reset to 0. `rst` overrides every input in the same cycle.
- Reset mid-frame: all outputs are 0 from the edge after `rst` is sampled high. The frame is dropped; no `frame_done` is issued.
- Latency: input sample k (k ≥ 1) → output slot 1 cycle after it is accepted.
- Flush slot: 1 cycle after sample N_PT−1 is accepted.
- `bf_en`, `tw_negj` and `valid_fac8_1` are aligned to the same output slot.
- Gap-free input: N_PT consecutive `valid_fac8_0` → N_PT consecutive `valid_fac8_1`, starting 2 cycles after the first input.
- Gaps: each gap cycle in the input delays every later output by 1 cycle. Output order is unchanged.

## Structure
- Package `fft_ctrl_pkg`:
  - FSM state enum `cu_state_e` (IDLE/RUN/DRAIN);
  - `N_PT` default;
  - twiddle-select encoding constants shared with the other module-1 control units.
- One sub-module, `cnt_frame`: CNT_W-bit counter with enable, synchronous clear/load-to-1, and terminal-count flag. It is instantiated twice, for `in_cnt` and `out_cnt`.
- The FSM and output registers live in the top level.

## Test plan
Bench runs with `N_PT`=8.
- Reset, then 8 gap-free valids with the alert on the first → `valid_fac8_1` high cycles 2–9; `alert_mod11` at cycle 2; `bf_en` per slot 1,0,1,0,1,0,1,0; `tw_negj` at slots 3 and 7; `frame_done` at cycle 9.
- Same frame with a 3-cycle gap after input sample 4 → outputs for samples 5–7 and the flush slot shifted 3 cycles; still 8 output valids.
- Two frames back-to-back (second alert on the DRAIN cycle) → 16 contiguous output valids; `alert_mod11` at cycles 2 and 10; no `err`.
- `valid_fac8_0` in IDLE with no alert → `err` pulse, no `valid_fac8_1`, state remains IDLE.
- Alert at input sample 5 of a frame → `err` pulse; restart; next 8 samples produce a clean frame with `alert_mod11`.
- `rst` asserted at input sample 4 → all outputs 0 next cycle; no `frame_done`; a fresh frame afterwards behaves as in scenario 1.

Source files
------------

// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT module-1 control-unit chain.
package fft_ctrl_pkg;

    localparam int unsigned N_PT_DEF = 512;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } cu_state_e;

    // Twiddle-select encoding common to all module-1 control units
    localparam int unsigned TW_SEL_W = 2;
    localparam logic [TW_SEL_W-1:0] TW_SEL_ONE  = 2'd0;
    localparam logic [TW_SEL_W-1:0] TW_SEL_NEGJ = 2'd1;
    localparam logic [TW_SEL_W-1:0] TW_SEL_W8   = 2'd2;
    localparam logic [TW_SEL_W-1:0] TW_SEL_W8_3 = 2'd3;

endpackage

// File: rtl/cu_mod1_1_cnt_frame.sv
// Frame sample counter: enable, sync clear, load-to-1 and terminal-count flag.
module cnt_frame
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned N_PT  = N_PT_DEF,
    parameter int unsigned CNT_W = $clog2(N_PT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             load1,
    output logic [CNT_W-1:0] cnt,
    output logic             tc_c
);

    assign tc_c = (cnt == CNT_W'(N_PT - 1));

    // clear wins over load, load wins over count
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (load1) begin
            cnt <= CNT_W'(1);
        end else if (en) begin
            cnt <= tc_c ? '0 : cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/cu_mod1_1.sv
// Control unit for the delay-1 SDF butterfly stage of FFT module 1.
module cu_mod1_1
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned N_PT  = N_PT_DEF,
    parameter int unsigned CNT_W = $clog2(N_PT)
) (
    input  logic clk,
    input  logic rst,
    input  logic valid_fac8_0,
    input  logic alert_mod10,
    output logic bf_en,
    output logic tw_negj,
    output logic valid_fac8_1,
    output logic alert_mod11,
    output logic frame_done,
    output logic err
);

    cu_state_e            state, state_nxt;
    logic [CNT_W-1:0]     in_cnt, out_cnt;
    logic                 in_tc, out_tc;
    logic                 in_en, in_load1, out_en, out_clr;
    logic                 vout_nxt, bf_nxt, done_nxt, err_nxt, alert_nxt;
    logic [TW_SEL_W-1:0]  tw_sel_c;

    cnt_frame #(.N_PT(N_PT), .CNT_W(CNT_W)) u_in_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (in_en),
        .clr   (1'b0),
        .load1 (in_load1),
        .cnt   (in_cnt),
        .tc_c  (in_tc)
    );

    cnt_frame #(.N_PT(N_PT), .CNT_W(CNT_W)) u_out_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (out_en),
        .clr   (out_clr),
        .load1 (1'b0),
        .cnt   (out_cnt),
        .tc_c  (out_tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, counter controls and next output-slot contents
    always_comb begin
        state_nxt = state;
        in_en     = 1'b0;
        in_load1  = 1'b0;
        out_en    = 1'b0;
        out_clr   = 1'b0;
        vout_nxt  = 1'b0;
        bf_nxt    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        case (state)
            IDLE: begin
                if (valid_fac8_0 && alert_mod10) begin
                    state_nxt = RUN;
                    in_load1  = 1'b1;
                    out_clr   = 1'b1;
                end else if (valid_fac8_0) begin
                    err_nxt = 1'b1;
                end
            end
            RUN: begin
                if (alert_mod10) begin
                    // restart: this sample becomes the new frame's buffered first
                    err_nxt  = 1'b1;
                    in_load1 = 1'b1;
                    out_clr  = 1'b1;
                end else if (valid_fac8_0) begin
                    vout_nxt = (in_cnt != '0);
                    bf_nxt   = in_cnt[0];
                    in_en    = 1'b1;
                    out_en   = (in_cnt != '0);
                    if (in_tc) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                vout_nxt = 1'b1;
                done_nxt = 1'b1;
                out_en   = 1'b1;
                out_clr  = out_tc;
                if (valid_fac8_0 && alert_mod10) begin
                    state_nxt = RUN;
                    in_load1  = 1'b1;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign tw_sel_c  = (vout_nxt && (out_cnt[1:0] == 2'b11)) ? TW_SEL_NEGJ : TW_SEL_ONE;
    assign alert_nxt = vout_nxt && (out_cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            bf_en        <= 1'b0;
            tw_negj      <= 1'b0;
            valid_fac8_1 <= 1'b0;
            alert_mod11  <= 1'b0;
            frame_done   <= 1'b0;
            err          <= 1'b0;
        end else begin
            bf_en        <= bf_nxt;
            tw_negj      <= (tw_sel_c == TW_SEL_NEGJ);
            valid_fac8_1 <= vout_nxt;
            alert_mod11  <= alert_nxt;
            frame_done   <= done_nxt;
            err          <= err_nxt;
        end
    end

endmodule

// File: tb/tb_cu_mod1_1.sv
// Scenario bench for cu_mod1_1 (N_PT=8) with a frame-level reference model.
module tb_cu_mod1_1;

    localparam int unsigned N = 8;

    logic clk = 1'b0;
    logic rst, valid_fac8_0, alert_mod10;
    logic bf_en, tw_negj, valid_fac8_1, alert_mod11, frame_done, err;

    int errors = 0;
    int checks = 0;

    // Model state: frame in progress, flush slot owed, samples taken, slots emitted
    bit          m_active, m_flush;
    int unsigned m_samples, m_outs;
    logic [5:0]  exp_o;

    cu_mod1_1 #(.N_PT(N), .CNT_W(3)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_fac8_0 (valid_fac8_0),
        .alert_mod10  (alert_mod10),
        .bf_en        (bf_en),
        .tw_negj      (tw_negj),
        .valid_fac8_1 (valid_fac8_1),
        .alert_mod11  (alert_mod11),
        .frame_done   (frame_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    // Packed view: {valid, bf_en, tw_negj, alert, done, err}
    function automatic logic [5:0] obs();
        return {valid_fac8_1, bf_en, tw_negj, alert_mod11, frame_done, err};
    endfunction

    function automatic logic [5:0] slot_bits(input bit bf, input bit done);
        logic [5:0] e;
        e    = '0;
        e[5] = 1'b1;
        e[4] = bf;
        e[3] = (m_outs % 4 == 3);
        e[2] = (m_outs == 0);
        e[1] = done;
        return e;
    endfunction

    task automatic model_step(input logic v, input logic a, input logic r);
        logic [5:0] e;
        e = '0;
        if (r) begin
            m_active = 0; m_flush = 0; m_samples = 0; m_outs = 0;
        end else if (m_flush) begin
            e = slot_bits(1'b0, 1'b1);
            m_outs  = (m_outs + 1) % N;
            m_flush = 0;
            m_active = (v && a);
            if (v && a) m_samples = 1;
        end else if (!m_active) begin
            if (v && a) begin
                m_active = 1; m_samples = 1; m_outs = 0;
            end else if (v) begin
                e[0] = 1'b1;
            end
        end else if (a) begin
            e[0] = 1'b1; m_samples = 1; m_outs = 0;
        end else if (v) begin
            e = slot_bits(m_samples % 2 == 1, 1'b0);
            m_outs    = (m_outs + 1) % N;
            m_samples = m_samples + 1;
            if (m_samples == N) m_flush = 1;
        end
        exp_o = e;
    endtask

    task automatic drive(input logic v, input logic a, input logic r);
        valid_fac8_0 = v;
        alert_mod10  = a;
        rst          = r;
        model_step(v, a, r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            checks++;
            if (obs() !== 6'b0) begin
                errors++;
                $display("FAIL reset c=%0d got=%b want=000000", c, obs());
            end
        end
    endtask

    task automatic test_gapfree(input string tag);
        logic [5:0] want;
        int t, slot;
        for (int c = 0; c < 12; c++) begin
            drive(c < N, c == 0, 1'b0);
            t = c + 1;
            want = '0;
            if (t >= 2 && t <= 9) begin
                slot    = t - 2;
                want[5] = 1'b1;
                want[4] = (slot % 2 == 0);
                want[3] = (slot == 3 || slot == 7);
                want[2] = (slot == 0);
                want[1] = (slot == 7);
            end
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL gapfree_%s t=%0d got=%b want=%b", tag, t, obs(), want);
            end
            checks++;
            if (obs() !== exp_o) begin
                errors++;
                $display("FAIL gapfree_%s_model t=%0d got=%b want=%b", tag, t, obs(), exp_o);
            end
        end
    endtask

    task automatic test_gap();
        int nval = 0;
        int t;
        logic [1:0] want;
        for (int c = 0; c < 16; c++) begin
            drive((c <= 4) || (c >= 8 && c <= 10), c == 0, 1'b0);
            t = c + 1;
            if (valid_fac8_1) nval++;
            want = {((t >= 2 && t <= 5) || (t >= 9 && t <= 12)), (t == 12)};
            checks++;
            if ({valid_fac8_1, frame_done} !== want) begin
                errors++;
                $display("FAIL gap t=%0d got=%b want=%b", t, {valid_fac8_1, frame_done}, want);
            end
            checks++;
            if (obs() !== exp_o) begin
                errors++;
                $display("FAIL gap_model t=%0d got=%b want=%b", t, obs(), exp_o);
            end
        end
        checks++;
        if (nval != 8) begin
            errors++;
            $display("FAIL gap_count got=%0d want=8", nval);
        end
    endtask

    task automatic test_back_to_back();
        int t;
        logic [3:0] want;
        for (int c = 0; c < 20; c++) begin
            drive(c < 2 * N, c == 0 || c == 8, 1'b0);
            t = c + 1;
            want = {(t >= 2 && t <= 17), (t == 2 || t == 10), (t == 9 || t == 17), 1'b0};
            checks++;
            if ({valid_fac8_1, alert_mod11, frame_done, err} !== want) begin
                errors++;
                $display("FAIL b2b t=%0d got=%b want=%b", t,
                         {valid_fac8_1, alert_mod11, frame_done, err}, want);
            end
            checks++;
            if (obs() !== exp_o) begin
                errors++;
                $display("FAIL b2b_model t=%0d got=%b want=%b", t, obs(), exp_o);
            end
        end
    endtask

    task automatic test_idle_err();
        int t;
        logic [5:0] want;
        for (int c = 0; c < 4; c++) begin
            drive(c < 2, 1'b0, 1'b0);
            t = c + 1;
            want = {5'b0, (t == 1 || t == 2)};
            checks++;
            if (obs() !== want) begin
                errors++;
                $display("FAIL idle_err t=%0d got=%b want=%b", t, obs(), want);
            end
        end
    endtask

    task automatic test_restart();
        int t;
        logic [3:0] want;
        for (int c = 0; c < 17; c++) begin
            drive(c <= 12, c == 0 || c == 5, 1'b0);
            t = c + 1;
            want = {((t >= 2 && t <= 5) || (t >= 7 && t <= 14)), (t == 2 || t == 7),
                    (t == 14), (t == 6)};
            checks++;
            if ({valid_fac8_1, alert_mod11, frame_done, err} !== want) begin
                errors++;
                $display("FAIL restart t=%0d got=%b want=%b", t,
                         {valid_fac8_1, alert_mod11, frame_done, err}, want);
            end
            checks++;
            if (obs() !== exp_o) begin
                errors++;
                $display("FAIL restart_model t=%0d got=%b want=%b", t, obs(), exp_o);
            end
        end
    endtask

    task automatic test_rst_mid();
        int t;
        logic [1:0] want;
        for (int c = 0; c < 10; c++) begin
            drive(c <= 4, c == 0, c == 4);
            t = c + 1;
            want = {(t >= 2 && t <= 4), 1'b0};
            checks++;
            if ({valid_fac8_1, frame_done} !== want) begin
                errors++;
                $display("FAIL rst_mid t=%0d got=%b want=%b", t, {valid_fac8_1, frame_done}, want);
            end
            if (t == 5) begin
                checks++;
                if (obs() !== 6'b0) begin
                    errors++;
                    $display("FAIL rst_mid_zero t=%0d got=%b want=000000", t, obs());
                end
            end
        end
        test_gapfree("fresh");
    endtask

    task automatic test_random();
        logic v, a, r;
        for (int c = 0; c < 600; c++) begin
            r = ($urandom_range(0, 199) == 0);
            v = ($urandom_range(0, 9) < 7);
            a = 1'b0;
            if (v) begin
                if (m_flush)       a = 1'($urandom_range(0, 1));
                else if (!m_active) a = ($urandom_range(0, 3) == 0);
                else               a = ($urandom_range(0, 59) == 0);
            end
            drive(v, a, r);
            checks++;
            if (obs() !== exp_o) begin
                errors++;
                $display("FAIL random c=%0d got=%b want=%b", c, obs(), exp_o);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        valid_fac8_0 = 1'b0;
        alert_mod10 = 1'b0;
        m_active = 0; m_flush = 0; m_samples = 0; m_outs = 0;
        exp_o = '0;
        drive(1'b0, 1'b0, 1'b1);
        test_reset();
        test_gapfree("first");
        test_gap();
        test_back_to_back();
        test_idle_err();
        test_restart();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
